vertexinput_regs_top: RTL and testbench

AXI4-Lite slave control/status register block for the vertex-input stage. It exposes two 32-bit descriptor registers (DESC_0 at 0x0, DESC_1 at 0x4). The fields are write-only, read-write, pulse, read-only, read-clear and write-1-to-clear types, and each field is presented as a dedicated port to the vertex-input logic. The block sits between the system AXI-Lite interconnect and the vertex-input datapath.

---
 rtl/vertexinput_pkg.sv | 53 +++++
 rtl/vertexinput_axil_if.sv | 179 +++++++++++++++++
 rtl/vertexinput_regs_top.sv | 223 ++++++++++++++++++++++
 tb/tb_vertexinput_regs_top.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vertexinput_pkg.sv
// Shared constants for the vertex-input descriptor register block: offsets, field layout, AXI responses.
// Optional feature macro: VERTEXINPUT_IRQ_EN (adds a registered irq output on the top).
package vertexinput_pkg;

   typedef logic [1:0] axi_resp_t;
   localparam axi_resp_t RESP_OKAY   = 2'b00;
   localparam axi_resp_t RESP_SLVERR = 2'b10;

   localparam logic [31:0] DESC0_OFF = 32'h0000_0000;
   localparam logic [31:0] DESC1_OFF = 32'h0000_0004;

   // DESC_0 field layout
   localparam int D0_CONFIG0_LSB    = 0;
   localparam int D0_CONFIG0_W      = 2;
   localparam int D0_CONFIG1_LSB    = 2;
   localparam int D0_CONFIG1_W      = 25;
   localparam int D0_STARTPULSE_LSB = 27;
   localparam int D0_STATUS_LSB     = 28;
   localparam int D0_STATUS_W       = 2;
   localparam int D0_IRQFLAG_LSB    = 30;
   localparam int D0_IRQFLAG_W      = 2;

   // DESC_1 field layout; bits [31:27] are reserved
   localparam int D1_CONFIG_LSB     = 0;
   localparam int D1_CONFIG_W       = 4;
   localparam int D1_LOGICSET_LSB   = 4;
   localparam int D1_LOGICSET_W     = 4;
   localparam int D1_READY_LSB      = 8;
   localparam int D1_READY_W        = 4;
   localparam int D1_IRQFLAG_LSB    = 12;
   localparam int D1_IRQFLAG_W      = 4;
   localparam int D1_STARTPIPE1_LSB = 16;
   localparam int D1_STICKY_LSB     = 17;
   localparam int D1_STICKY_W       = 9;
   localparam int D1_STARTPIPE2_LSB = 26;

   // Per-channel handshake state, shared by the read and write sides
   typedef enum logic [1:0] {
      CH_IDLE = 2'd0,
      CH_ACK  = 2'd1,
      CH_RESP = 2'd2
   } ch_state_t;

   function automatic logic [31:0] byte_mask(input logic [3:0] strb);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/vertexinput_axil_if.sv
// AXI4-Lite slave handshake engine: turns bus transactions into single-cycle wr_en / rd_en strobes.
// Optional feature macro VERTEXINPUT_IRQ_EN lives in the top; this file is unaffected by it.
module vertexinput_axil_if
   import vertexinput_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic [ADDR_W-1:0]     s_axi_awaddr,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [DATA_W-1:0]     s_axi_wdata,
   input  logic [DATA_W/8-1:0]   s_axi_wstrb,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   output logic [1:0]            s_axi_bresp,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   input  logic [ADDR_W-1:0]     s_axi_araddr,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   output logic [DATA_W-1:0]     s_axi_rdata,
   output logic [1:0]            s_axi_rresp,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic                  wr_en,
   output logic [ADDR_W-1:0]     wr_addr,
   output logic [DATA_W-1:0]     wr_data,
   output logic [DATA_W/8-1:0]   wr_strb,
   input  logic                  wr_err,
   output logic                  rd_en,
   output logic [ADDR_W-1:0]     rd_addr,
   input  logic [DATA_W-1:0]     rd_data,
   input  logic                  rd_err,
   output ch_state_t             wr_state,
   output ch_state_t             rd_state
);

   // Valid/ready: a channel transfer happens on the edge where valid and ready are both high;
   // the slave raises awready/wready/arready for exactly one cycle after seeing valid, and
   // holds bvalid/rvalid with stable payload until the master's bready/rready is sampled high.

   ch_state_t             wr_state_q, wr_state_d, rd_state_q, rd_state_d;
   logic                  awready_q, awready_d, wready_q, wready_d, wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
   logic [DATA_W-1:0]     wr_data_q, wr_data_d, rdata_q, rdata_d;
   logic [DATA_W/8-1:0]   wr_strb_q, wr_strb_d;
   logic                  bvalid_q, bvalid_d, arready_q, arready_d, rd_en_q, rd_en_d;
   logic                  rvalid_q, rvalid_d;
   axi_resp_t             bresp_q, bresp_d, rresp_q, rresp_d;

   always_comb begin
      wr_state_d = wr_state_q;
      awready_d  = 1'b0;
      wready_d   = 1'b0;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      wr_strb_d  = wr_strb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      case (wr_state_q)
         CH_IDLE: begin
            if (s_axi_awvalid && s_axi_wvalid) begin
               wr_state_d = CH_ACK;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
               wr_en_d    = 1'b1;
               wr_addr_d  = s_axi_awaddr;
               wr_data_d  = s_axi_wdata;
               wr_strb_d  = s_axi_wstrb;
            end
         end
         CH_ACK: begin
            wr_state_d = CH_RESP;
            bvalid_d   = 1'b1;
            bresp_d    = wr_err ? RESP_SLVERR : RESP_OKAY;
         end
         CH_RESP: begin
            if (s_axi_bready) begin
               wr_state_d = CH_IDLE;
               bvalid_d   = 1'b0;
            end
         end
         default: wr_state_d = CH_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      arready_d  = 1'b0;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      rvalid_d   = rvalid_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (rd_state_q)
         CH_IDLE: begin
            if (s_axi_arvalid) begin
               rd_state_d = CH_ACK;
               arready_d  = 1'b1;
               rd_en_d    = 1'b1;
               rd_addr_d  = s_axi_araddr;
            end
         end
         CH_ACK: begin
            rd_state_d = CH_RESP;
            rvalid_d   = 1'b1;
            rdata_d    = rd_err ? '0 : rd_data;
            rresp_d    = rd_err ? RESP_SLVERR : RESP_OKAY;
         end
         CH_RESP: begin
            if (s_axi_rready) begin
               rd_state_d = CH_IDLE;
               rvalid_d   = 1'b0;
            end
         end
         default: rd_state_d = CH_IDLE;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         wr_state_q <= CH_IDLE;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         wr_strb_q  <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rd_state_q <= CH_IDLE;
         arready_q  <= 1'b0;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         wr_strb_q  <= wr_strb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = rresp_q;
   assign wr_en         = wr_en_q;
   assign wr_addr       = wr_addr_q;
   assign wr_data       = wr_data_q;
   assign wr_strb       = wr_strb_q;
   assign rd_en         = rd_en_q;
   assign rd_addr       = rd_addr_q;
   assign wr_state      = wr_state_q;
   assign rd_state      = rd_state_q;

endmodule

// File: rtl/vertexinput_regs_top.sv
// Vertex-input descriptor registers (DESC_0 @0x0, DESC_1 @0x4): field storage, side effects and read mux.
// Define VERTEXINPUT_IRQ_EN to add a registered irq output (OR of the rc and w1c latches).
module vertexinput_regs_top
   import vertexinput_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                aclk,
   input  logic                areset,
`ifdef VERTEXINPUT_IRQ_EN
   output logic                irq,
`endif
   input  logic [ADDR_W-1:0]   s_axi_awaddr,
   input  logic                s_axi_awvalid,
   output logic                s_axi_awready,
   input  logic [DATA_W-1:0]   s_axi_wdata,
   input  logic [DATA_W/8-1:0] s_axi_wstrb,
   input  logic                s_axi_wvalid,
   output logic                s_axi_wready,
   output logic [1:0]          s_axi_bresp,
   output logic                s_axi_bvalid,
   input  logic                s_axi_bready,
   input  logic [ADDR_W-1:0]   s_axi_araddr,
   input  logic                s_axi_arvalid,
   output logic                s_axi_arready,
   output logic [DATA_W-1:0]   s_axi_rdata,
   output logic [1:0]          s_axi_rresp,
   output logic                s_axi_rvalid,
   input  logic                s_axi_rready,
   output logic [1:0]          REG_DESC_0_config0_wo,
   output logic [24:0]         REG_DESC_0_config1_rw,
   output logic                REG_DESC_0_startpulse_pulse,
   input  logic [1:0]          REG_DESC_0_status_ro,
   input  logic [1:0]          REG_DESC_0_interruptflag_rc_in,
   output logic [1:0]          REG_DESC_0_interruptflag_rc_clr,
   output logic [3:0]          REG_DESC_1_config_rw,
   output logic [3:0]          REG_DESC_1_logicset_wo,
   input  logic [3:0]          REG_DESC_1_readystatus_ro,
   input  logic [3:0]          REG_DESC_1_interruptflag_rc_in,
   output logic [3:0]          REG_DESC_1_interruptflag_rc_clr,
   output logic                REG_DESC_1_startpipe1_pulse,
   input  logic [8:0]          REG_DESC_1_stickybit_w1c_in,
   output logic [8:0]          REG_DESC_1_stickybit_w1c_clr,
   output logic                REG_DESC_1_startpipe2_pulse
);

   logic                wr_en, rd_en, wr_err, rd_err;
   logic [ADDR_W-1:0]   wr_addr, rd_addr;
   logic [DATA_W-1:0]   wr_data, rd_data;
   logic [DATA_W/8-1:0] wr_strb;
   ch_state_t           wr_state, rd_state;

   vertexinput_axil_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_axil_if (
      .aclk          (aclk),
      .areset        (areset),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_strb       (wr_strb),
      .wr_err        (wr_err),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_err        (rd_err),
      .wr_state      (wr_state),
      .rd_state      (rd_state)
   );

   // Address bits [1:0] never take part in decode
   logic wr_match0, wr_match1, rd_match0, rd_match1;
   logic wr_hit0, wr_hit1, rd_hit0, rd_hit1;
   logic [31:0] bm;

   assign wr_match0 = (wr_addr[ADDR_W-1:2] == DESC0_OFF[ADDR_W-1:2]);
   assign wr_match1 = (wr_addr[ADDR_W-1:2] == DESC1_OFF[ADDR_W-1:2]);
   assign rd_match0 = (rd_addr[ADDR_W-1:2] == DESC0_OFF[ADDR_W-1:2]);
   assign rd_match1 = (rd_addr[ADDR_W-1:2] == DESC1_OFF[ADDR_W-1:2]);
   assign wr_hit0   = wr_en && wr_match0;
   assign wr_hit1   = wr_en && wr_match1;
   assign rd_hit0   = rd_en && rd_match0;
   assign rd_hit1   = rd_en && rd_match1;
   assign wr_err    = !(wr_match0 || wr_match1);
   assign rd_err    = !(rd_match0 || rd_match1);
   assign bm        = byte_mask(wr_strb);

   logic [1:0]  cfg0_q, cfg0_d, rc0_q, rc0_d, rc0_clr_q, rc0_clr_d;
   logic [24:0] cfg1_q, cfg1_d;
   logic [3:0]  d1cfg_q, d1cfg_d, lset_q, lset_d, rc1_q, rc1_d, rc1_clr_q, rc1_clr_d;
   logic [8:0]  w1c_q, w1c_d, w1c_clr_q, w1c_clr_d;
   logic        spulse_q, spulse_d, pipe1_q, pipe1_d, pipe2_q, pipe2_d;

   always_comb begin
      cfg0_d    = cfg0_q;
      cfg1_d    = cfg1_q;
      d1cfg_d   = d1cfg_q;
      lset_d    = lset_q;
      spulse_d  = 1'b0;
      pipe1_d   = 1'b0;
      pipe2_d   = 1'b0;
      w1c_clr_d = '0;
      if (wr_hit0) begin
         cfg0_d   = (cfg0_q & ~bm[D0_CONFIG0_LSB +: D0_CONFIG0_W])
                  | (wr_data[D0_CONFIG0_LSB +: D0_CONFIG0_W] & bm[D0_CONFIG0_LSB +: D0_CONFIG0_W]);
         cfg1_d   = (cfg1_q & ~bm[D0_CONFIG1_LSB +: D0_CONFIG1_W])
                  | (wr_data[D0_CONFIG1_LSB +: D0_CONFIG1_W] & bm[D0_CONFIG1_LSB +: D0_CONFIG1_W]);
         spulse_d = wr_data[D0_STARTPULSE_LSB] & bm[D0_STARTPULSE_LSB];
      end
      if (wr_hit1) begin
         d1cfg_d   = (d1cfg_q & ~bm[D1_CONFIG_LSB +: D1_CONFIG_W])
                   | (wr_data[D1_CONFIG_LSB +: D1_CONFIG_W] & bm[D1_CONFIG_LSB +: D1_CONFIG_W]);
         lset_d    = (lset_q & ~bm[D1_LOGICSET_LSB +: D1_LOGICSET_W])
                   | (wr_data[D1_LOGICSET_LSB +: D1_LOGICSET_W] & bm[D1_LOGICSET_LSB +: D1_LOGICSET_W]);
         pipe1_d   = wr_data[D1_STARTPIPE1_LSB] & bm[D1_STARTPIPE1_LSB];
         pipe2_d   = wr_data[D1_STARTPIPE2_LSB] & bm[D1_STARTPIPE2_LSB];
         w1c_clr_d = wr_data[D1_STICKY_LSB +: D1_STICKY_W] & bm[D1_STICKY_LSB +: D1_STICKY_W];
      end
      // Clear what the read returned; a new set on the same edge is OR'd back in afterwards
      rc0_clr_d = rd_hit0 ? rc0_q : '0;
      rc1_clr_d = rd_hit1 ? rc1_q : '0;
      rc0_d     = (rc0_q & ~rc0_clr_d) | REG_DESC_0_interruptflag_rc_in;
      rc1_d     = (rc1_q & ~rc1_clr_d) | REG_DESC_1_interruptflag_rc_in;
      w1c_d     = (w1c_q & ~w1c_clr_d) | REG_DESC_1_stickybit_w1c_in;
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         cfg0_q    <= '0;
         cfg1_q    <= '0;
         d1cfg_q   <= '0;
         lset_q    <= '0;
         spulse_q  <= 1'b0;
         pipe1_q   <= 1'b0;
         pipe2_q   <= 1'b0;
         rc0_q     <= '0;
         rc1_q     <= '0;
         rc0_clr_q <= '0;
         rc1_clr_q <= '0;
         w1c_q     <= '0;
         w1c_clr_q <= '0;
      end else begin
         cfg0_q    <= cfg0_d;
         cfg1_q    <= cfg1_d;
         d1cfg_q   <= d1cfg_d;
         lset_q    <= lset_d;
         spulse_q  <= spulse_d;
         pipe1_q   <= pipe1_d;
         pipe2_q   <= pipe2_d;
         rc0_q     <= rc0_d;
         rc1_q     <= rc1_d;
         rc0_clr_q <= rc0_clr_d;
         rc1_clr_q <= rc1_clr_d;
         w1c_q     <= w1c_d;
         w1c_clr_q <= w1c_clr_d;
      end
   end

   // Write-only and pulse fields read back as zero; ro fields are sampled live in the arready cycle
   always_comb begin
      rd_data = '0;
      if (rd_match0) begin
         rd_data[D0_CONFIG1_LSB +: D0_CONFIG1_W] = cfg1_q;
         rd_data[D0_STATUS_LSB +: D0_STATUS_W]   = REG_DESC_0_status_ro;
         rd_data[D0_IRQFLAG_LSB +: D0_IRQFLAG_W] = rc0_q;
      end else if (rd_match1) begin
         rd_data[D1_CONFIG_LSB +: D1_CONFIG_W]   = d1cfg_q;
         rd_data[D1_READY_LSB +: D1_READY_W]     = REG_DESC_1_readystatus_ro;
         rd_data[D1_IRQFLAG_LSB +: D1_IRQFLAG_W] = rc1_q;
         rd_data[D1_STICKY_LSB +: D1_STICKY_W]   = w1c_q;
      end
   end

`ifdef VERTEXINPUT_IRQ_EN
   logic irq_q, irq_d;

   always_comb begin
      irq_d = (|rc0_q) | (|rc1_q) | (|w1c_q);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

   assign REG_DESC_0_config0_wo           = cfg0_q;
   assign REG_DESC_0_config1_rw           = cfg1_q;
   assign REG_DESC_0_startpulse_pulse     = spulse_q;
   assign REG_DESC_0_interruptflag_rc_clr = rc0_clr_q;
   assign REG_DESC_1_config_rw            = d1cfg_q;
   assign REG_DESC_1_logicset_wo          = lset_q;
   assign REG_DESC_1_interruptflag_rc_clr = rc1_clr_q;
   assign REG_DESC_1_startpipe1_pulse     = pipe1_q;
   assign REG_DESC_1_stickybit_w1c_clr    = w1c_clr_q;
   assign REG_DESC_1_startpipe2_pulse     = pipe2_q;

   // Sub-word address bits, the unmapped data/strobe lanes and channel state carry no function here
   logic unused_bits;
   assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0], wr_data[31:28], bm[31:28], wr_state, rd_state};

endmodule

// File: tb/tb_vertexinput_regs_top.sv
// Self-checking bench for vertexinput_regs_top: vector table plus hand sequences for rc, w1c, pulses and reset abort.
// Builds with or without VERTEXINPUT_IRQ_EN.
module tb_vertexinput_regs_top;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic [1:0]  cfg0, status_ro, rc0_in, rc0_clr;
   logic [24:0] cfg1;
   logic        spulse, pipe1, pipe2;
   logic [3:0]  d1cfg, lset, ready_ro, rc1_in, rc1_clr;
   logic [8:0]  w1c_in, w1c_clr;
`ifdef VERTEXINPUT_IRQ_EN
   logic        irq;
`endif

   vertexinput_regs_top #(.ADDR_W(32), .DATA_W(32)) dut (
      .aclk                            (aclk),
      .areset                          (areset),
`ifdef VERTEXINPUT_IRQ_EN
      .irq                             (irq),
`endif
      .s_axi_awaddr                    (awaddr),
      .s_axi_awvalid                   (awvalid),
      .s_axi_awready                   (awready),
      .s_axi_wdata                     (wdata),
      .s_axi_wstrb                     (wstrb),
      .s_axi_wvalid                    (wvalid),
      .s_axi_wready                    (wready),
      .s_axi_bresp                     (bresp),
      .s_axi_bvalid                    (bvalid),
      .s_axi_bready                    (bready),
      .s_axi_araddr                    (araddr),
      .s_axi_arvalid                   (arvalid),
      .s_axi_arready                   (arready),
      .s_axi_rdata                     (rdata),
      .s_axi_rresp                     (rresp),
      .s_axi_rvalid                    (rvalid),
      .s_axi_rready                    (rready),
      .REG_DESC_0_config0_wo           (cfg0),
      .REG_DESC_0_config1_rw           (cfg1),
      .REG_DESC_0_startpulse_pulse     (spulse),
      .REG_DESC_0_status_ro            (status_ro),
      .REG_DESC_0_interruptflag_rc_in  (rc0_in),
      .REG_DESC_0_interruptflag_rc_clr (rc0_clr),
      .REG_DESC_1_config_rw            (d1cfg),
      .REG_DESC_1_logicset_wo          (lset),
      .REG_DESC_1_readystatus_ro       (ready_ro),
      .REG_DESC_1_interruptflag_rc_in  (rc1_in),
      .REG_DESC_1_interruptflag_rc_clr (rc1_clr),
      .REG_DESC_1_startpipe1_pulse     (pipe1),
      .REG_DESC_1_stickybit_w1c_in     (w1c_in),
      .REG_DESC_1_stickybit_w1c_clr    (w1c_clr),
      .REG_DESC_1_startpipe2_pulse     (pipe2)
   );

   always #5 aclk = ~aclk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [33:0] exp_q[$];
   logic [1:0]  cap_resp;
   logic [2:0]  cap_pulse, aft_pulse;
   logic [8:0]  cap_w1c, aft_w1c;
   logic [1:0]  cap_rc0, aft_rc0;
   logic [3:0]  cap_rc1, aft_rc1;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  resp;
      logic [31:0] rdata;
      logic [34:0] ports;
      logic        sp;
   } vec_t;

   localparam logic [34:0] P_ALL = {2'd3, 25'h1FFFFFF, 4'h0, 4'h0};
   localparam logic [34:0] P_A   = {2'd3, 25'h1FFFFFF, 4'hA, 4'h0};
   localparam logic [34:0] P_5F  = {2'd3, 25'h1FFFFFF, 4'h5, 4'hF};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int t;
      @(negedge aclk);
      awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
      t = 0;
      do begin @(negedge aclk); t++; end while (!(awready && wready) && t < 20);
      check("aw_w_ready_latency", t, 1);
      awvalid = 1'b0; wvalid = 1'b0;
      t = 0;
      do begin @(negedge aclk); t++; end while (!bvalid && t < 20);
      check("bvalid_latency", t, 1);
      cap_resp  = bresp;
      cap_pulse = {spulse, pipe1, pipe2};
      cap_w1c   = w1c_clr;
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      aft_pulse = {spulse, pipe1, pipe2};
      aft_w1c   = w1c_clr;
   endtask

   task automatic axi_read(input logic [31:0] a, input logic [1:0] er, input logic [31:0] ed, input string name);
      int t;
      logic [33:0] exp;
      exp_q.push_back({er, ed});
      @(negedge aclk);
      araddr = a; arvalid = 1'b1;
      t = 0;
      do begin @(negedge aclk); t++; end while (!arready && t < 20);
      check("arready_latency", t, 1);
      arvalid = 1'b0;
      t = 0;
      do begin @(negedge aclk); t++; end while (!rvalid && t < 20);
      check("rvalid_latency", t, 1);
      cap_rc0 = rc0_clr;
      cap_rc1 = rc1_clr;
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         check(name, {rresp, rdata}, exp);
      end
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
      aft_rc0 = rc0_clr;
      aft_rc1 = rc1_clr;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[12];
      logic seen_b;

      areset = 1'b1;
      awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arvalid = 1'b0; rready = 1'b0;
      status_ro = '0; rc0_in = '0; ready_ro = '0; rc1_in = '0; w1c_in = '0;

      tbl[0]  = '{1'b1, 32'h0,  32'h0FFF_FFFF, 4'hF, 2'b00, 32'h0,         P_ALL, 1'b1};
      tbl[1]  = '{1'b0, 32'h0,  32'h0,         4'h0, 2'b00, 32'h07FF_FFFC, P_ALL, 1'b0};
      tbl[2]  = '{1'b1, 32'h4,  32'h0000_000A, 4'h1, 2'b00, 32'h0,         P_A,   1'b0};
      tbl[3]  = '{1'b0, 32'h4,  32'h0,         4'h0, 2'b00, 32'h0000_000A, P_A,   1'b0};
      tbl[4]  = '{1'b1, 32'h4,  32'h0000_00FF, 4'h2, 2'b00, 32'h0,         P_A,   1'b0};
      tbl[5]  = '{1'b0, 32'h4,  32'h0,         4'h0, 2'b00, 32'h0000_000A, P_A,   1'b0};
      tbl[6]  = '{1'b1, 32'h8,  32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0,         P_A,   1'b0};
      tbl[7]  = '{1'b0, 32'h0,  32'h0,         4'h0, 2'b00, 32'h07FF_FFFC, P_A,   1'b0};
      tbl[8]  = '{1'b0, 32'h10, 32'h0,         4'h0, 2'b10, 32'h0,         P_A,   1'b0};
      tbl[9]  = '{1'b0, 32'h3,  32'h0,         4'h0, 2'b00, 32'h07FF_FFFC, P_A,   1'b0};
      tbl[10] = '{1'b1, 32'h4,  32'h0000_00F5, 4'h1, 2'b00, 32'h0,         P_5F,  1'b0};
      tbl[11] = '{1'b0, 32'h4,  32'h0,         4'h0, 2'b00, 32'h0000_0005, P_5F,  1'b0};

      // clock/reset
      repeat (3) @(negedge aclk);
      areset = 1'b0;
      @(negedge aclk);
      check("reset_handshake", {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata}, 64'd0);
      check("reset_fields", {cfg0, cfg1, spulse, rc0_clr, d1cfg, lset, rc1_clr, pipe1, w1c_clr, pipe2}, 64'd0);
      axi_read(32'h0, 2'b00, 32'h0, "reset_read_desc0");
      axi_read(32'h4, 2'b00, 32'h0, "reset_read_desc1");

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].wr) begin
            axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
            check($sformatf("row%0d_bresp", i), cap_resp, tbl[i].resp);
            check($sformatf("row%0d_ports", i), {cfg0, cfg1, d1cfg, lset}, tbl[i].ports);
            check($sformatf("row%0d_startpulse", i), cap_pulse[2], tbl[i].sp);
            check($sformatf("row%0d_pulse_after", i), aft_pulse, 3'b000);
         end else begin
            axi_read(tbl[i].addr, tbl[i].resp, tbl[i].rdata, $sformatf("row%0d_read", i));
         end
      end

      // lane 2 strobed off: startpipe1 must not fire, startpipe2 (lane 3) must
      axi_write(32'h4, 32'h0401_0005, 4'hB);
      check("pipe_pulses", cap_pulse, 3'b001);
      check("pipe_pulses_after", aft_pulse, 3'b000);
      check("pipe_ports", {d1cfg, lset}, {4'h5, 4'h0});

      // rc on DESC_0 with live status
      status_ro = 2'b01;
      @(negedge aclk); rc0_in = 2'b10;
      @(negedge aclk); rc0_in = 2'b00;
      axi_read(32'h0, 2'b00, 32'h97FF_FFFC, "rc0_first_read");
      check("rc0_clr_pulse", cap_rc0, 2'b10);
      check("rc0_clr_after", aft_rc0, 2'b00);
      axi_read(32'h0, 2'b00, 32'h17FF_FFFC, "rc0_second_read");
      check("rc0_clr_second", cap_rc0, 2'b00);

      // w1c and rc on DESC_1
      ready_ro = 4'hC;
      @(negedge aclk); w1c_in = 9'h1FF; rc1_in = 4'h5;
      @(negedge aclk); w1c_in = 9'h000; rc1_in = 4'h0;
      axi_read(32'h4, 2'b00, 32'h03FE_5C05, "w1c_first_read");
      check("rc1_clr_pulse", cap_rc1, 4'h5);
      axi_write(32'h4, 32'h0006_0000, 4'h4);
      check("w1c_bresp", cap_resp, 2'b00);
      check("w1c_clr_pulse", cap_w1c, 9'h003);
      check("w1c_clr_after", aft_w1c, 9'h000);
      axi_read(32'h4, 2'b00, 32'h03F8_0C05, "w1c_reread");

      // reset between aw acceptance and bvalid: no response ever appears
      @(negedge aclk);
      awaddr = 32'h4; wdata = 32'h0000_00FF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      begin
         int t;
         t = 0;
         do begin @(negedge aclk); t++; end while (!awready && t < 20);
         check("abort_aw_latency", t, 1);
      end
      areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0;
      @(negedge aclk);
      seen_b = bvalid;
      areset = 1'b0;
      bready = 1'b1;
      repeat (4) begin
         @(negedge aclk);
         seen_b = seen_b | bvalid;
      end
      bready = 1'b0;
      check("abort_no_bvalid", seen_b, 1'b0);
      check("abort_fields_reset", {cfg0, cfg1, d1cfg, lset}, 35'd0);
      axi_read(32'h4, 2'b00, 32'h0000_0C00, "abort_read_desc1");
      axi_read(32'h0, 2'b00, 32'h1000_0000, "abort_read_desc0");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
